// File: rtl/ctrl_pkg.sv
// Shared constants, types and helpers for the pipelined RV32I control decoder.
// ALU codes, opcode[6:2] values, the control bundle and the trap FSM states.
package ctrl_pkg;

   localparam logic [3:0] ALU_SLL  = 4'd0;
   localparam logic [3:0] ALU_SRA  = 4'd1;
   localparam logic [3:0] ALU_SRL  = 4'd2;
   localparam logic [3:0] ALU_ADD  = 4'd5;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_XOR  = 4'd9;
   localparam logic [3:0] ALU_SLT  = 4'd11;
   localparam logic [3:0] ALU_SLTU = 4'd12;

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_IALU   = 5'b00100;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_RTYPE  = 5'b01100;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_SYSTEM = 5'b11100;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_TRAP = 1'b1
   } trap_state_t;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src;
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic       sb;
      logic       s_type;
      logic       beq;
      logic       bne;
      logic       bltu;
      logic       jal;
      logic       jalr;
      logic       csrrsi;
      logic       csrrci;
      logic       ecall;
      logic       uret;
      logic       illegal;
   } ctrl_bundle_t;

   // alt selects SUB over ADD (funct3=000) and SRA over SRL (funct3=101)
   function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
      logic [3:0] v;
      case (f3)
         3'b000:  v = alt ? ALU_SUB : ALU_ADD;
         3'b001:  v = ALU_SLL;
         3'b010:  v = ALU_SLT;
         3'b011:  v = ALU_SLTU;
         3'b100:  v = ALU_XOR;
         3'b101:  v = alt ? ALU_SRA : ALU_SRL;
         3'b110:  v = ALU_OR;
         3'b111:  v = ALU_AND;
         default: v = ALU_ADD;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational instruction-field to control-bundle decode.
// Any illegal encoding yields an all-zero bundle with only illegal set.
module ctrl_decode_comb
   import ctrl_pkg::*;
#(
   parameter int EN_CSR = 1
) (
   input  logic [4:0]   i_op,
   input  logic [2:0]   i_funct3,
   input  logic         i_f25,
   input  logic         i_f30,
   input  logic         i_ir21,
   output ctrl_bundle_t o_bundle
);

   ctrl_bundle_t w_dec;
   ctrl_bundle_t w_illegal;

   // Field decode; R-type with instr[25] set is an M-extension op, not RV32I
   always_comb begin
      w_dec = '0;
      case (i_op)
         OP_RTYPE: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_op    = alu_from_funct(i_funct3, i_f30);
            w_dec.illegal   = i_f25;
         end
         OP_IALU: begin
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.alu_op    = alu_from_funct(i_funct3, i_f30 && (i_funct3 == 3'b101));
         end
         OP_LOAD: begin
            w_dec.alu_src    = 1'b1;
            w_dec.reg_write  = 1'b1;
            w_dec.mem_to_reg = 1'b1;
            w_dec.alu_op     = ALU_ADD;
            w_dec.illegal    = (i_funct3 != 3'b010);
         end
         OP_STORE: begin
            w_dec.alu_src   = 1'b1;
            w_dec.mem_write = 1'b1;
            w_dec.s_type    = 1'b1;
            w_dec.alu_op    = ALU_ADD;
            w_dec.sb        = (i_funct3 == 3'b000);
            w_dec.illegal   = (i_funct3 != 3'b000) && (i_funct3 != 3'b010);
         end
         OP_BRANCH: begin
            w_dec.alu_op  = ALU_SUB;
            w_dec.beq     = (i_funct3 == 3'b000);
            w_dec.bne     = (i_funct3 == 3'b001);
            w_dec.bltu    = (i_funct3 == 3'b110);
            w_dec.illegal = !(w_dec.beq || w_dec.bne || w_dec.bltu);
         end
         OP_JAL: begin
            w_dec.jal       = 1'b1;
            w_dec.reg_write = 1'b1;
         end
         OP_JALR: begin
            w_dec.jalr      = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.alu_op    = ALU_ADD;
         end
         OP_SYSTEM: begin
            case (i_funct3)
               3'b000: begin
                  w_dec.ecall = !i_ir21;
                  w_dec.uret  = i_ir21;
               end
               3'b110: begin
                  w_dec.csrrsi    = (EN_CSR != 0);
                  w_dec.reg_write = (EN_CSR != 0);
                  w_dec.illegal   = (EN_CSR == 0);
               end
               3'b111: begin
                  w_dec.csrrci    = (EN_CSR != 0);
                  w_dec.reg_write = (EN_CSR != 0);
                  w_dec.illegal   = (EN_CSR == 0);
               end
               default: w_dec.illegal = 1'b1;
            endcase
         end
         default: w_dec.illegal = 1'b1;
      endcase
   end

   // Illegal bundle: nothing writes, branches or jumps
   always_comb begin
      w_illegal         = '0;
      w_illegal.illegal = 1'b1;
   end

   assign o_bundle = w_dec.illegal ? w_illegal : w_dec;

endmodule

// File: rtl/ctrl_unit_pipe.sv
// Registered ID/EX control decoder with valid/ready, stall/flush handling and
// a trap sequencer that blocks new instructions while ecall/uret complete.
module ctrl_unit_pipe
   import ctrl_pkg::*;
#(
   parameter int ALUOP_W     = 4,
   parameter int TRAP_CYCLES = 2,
   parameter int EN_CSR      = 1
) (
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4:0]         OP,
   input  logic [2:0]         Funct3,
   input  logic               F25,
   input  logic               F30,
   input  logic               IR21,
   input  logic               stall,
   input  logic               flush,
   output logic               out_valid,
   output logic [ALUOP_W-1:0] ALU_OP,
   output logic               ALU_SRC,
   output logic               RegWrite,
   output logic               MemToReg,
   output logic               MemWrite,
   output logic               SB,
   output logic               S_type,
   output logic               Beq,
   output logic               Bne,
   output logic               BLTU,
   output logic               JAL,
   output logic               Jalr,
   output logic               CSRRSI,
   output logic               CSRRCI,
   output logic               ecall,
   output logic               uret,
   output logic               illegal,
   output logic               trap_busy
);

   localparam logic [3:0] TRAP_LOAD = 4'(TRAP_CYCLES);

   ctrl_bundle_t w_dec;
   ctrl_bundle_t r_bundle;
   logic         r_valid;
   trap_state_t  r_state;
   trap_state_t  w_state_nxt;
   logic [3:0]   r_cnt;
   logic [3:0]   w_cnt_nxt;
   logic         w_accept;
   logic         w_trap_start;

   ctrl_decode_comb #(.EN_CSR(EN_CSR)) u_decode (
      .i_op     (OP),
      .i_funct3 (Funct3),
      .i_f25    (F25),
      .i_f30    (F30),
      .i_ir21   (IR21),
      .o_bundle (w_dec)
   );

   assign in_ready     = !stall && (r_state == ST_IDLE);
   assign w_accept     = in_valid && in_ready;
   assign w_trap_start = w_accept && !flush && (w_dec.ecall || w_dec.uret);

   // ID/EX register: flush > stall > accept > bubble
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         r_valid  <= 1'b0;
         r_bundle <= '0;
      end else if (flush) begin
         r_valid  <= 1'b0;
         r_bundle <= '0;
      end else if (stall) begin
         r_valid  <= r_valid;
         r_bundle <= r_bundle;
      end else if (w_accept) begin
         r_valid  <= 1'b1;
         r_bundle <= w_dec;
      end else begin
         r_valid  <= 1'b0;
         r_bundle <= '0;
      end
   end

   // Trap sequencer state and hold counter
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Counter keeps running through stall and flush once a trap has started
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_trap_start) begin
               w_state_nxt = ST_TRAP;
               w_cnt_nxt   = TRAP_LOAD;
            end else begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 4'd0;
            end
         end
         ST_TRAP: begin
            if (r_cnt <= 4'd1) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_state_nxt = ST_TRAP;
               w_cnt_nxt   = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // r_bundle is all-zero whenever r_valid is low, so the controls are valid-gated
   assign out_valid = r_valid;
   assign ALU_OP    = ALUOP_W'(r_bundle.alu_op);
   assign ALU_SRC   = r_bundle.alu_src;
   assign RegWrite  = r_bundle.reg_write;
   assign MemToReg  = r_bundle.mem_to_reg;
   assign MemWrite  = r_bundle.mem_write;
   assign SB        = r_bundle.sb;
   assign S_type    = r_bundle.s_type;
   assign Beq       = r_bundle.beq;
   assign Bne       = r_bundle.bne;
   assign BLTU      = r_bundle.bltu;
   assign JAL       = r_bundle.jal;
   assign Jalr      = r_bundle.jalr;
   assign CSRRSI    = r_bundle.csrrsi;
   assign CSRRCI    = r_bundle.csrrci;
   assign ecall     = r_bundle.ecall;
   assign uret      = r_bundle.uret;
   assign illegal   = r_bundle.illegal;
   assign trap_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level reference model, on two configurations of the decoder.
module tb_ctrl_unit_pipe;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic       rst_n, in_valid, stall, flush, f25, f30, ir21;
   logic [4:0] op;
   logic [2:0] f3;

   logic       rdy0, ov0, src0, rw0, m2r0, mw0, sb0, st0, beq0, bne0, bltu0;
   logic       jal0, jalr0, rsi0, rci0, ec0, ur0, ill0, busy0;
   logic [3:0] aop0;
   logic       rdy1, ov1, src1, rw1, m2r1, mw1, sb1, st1, beq1, bne1, bltu1;
   logic       jal1, jalr1, rsi1, rci1, ec1, ur1, ill1, busy1;
   logic [4:0] aop1;

   wire [21:0] act0 = {1'b0, ov0, aop0, src0, rw0, m2r0, mw0, sb0, st0, beq0, bne0,
                       bltu0, jal0, jalr0, rsi0, rci0, ec0, ur0, ill0};
   wire [21:0] act1 = {aop1[4], ov1, aop1[3:0], src1, rw1, m2r1, mw1, sb1, st1, beq1, bne1,
                       bltu1, jal1, jalr1, rsi1, rci1, ec1, ur1, ill1};

   ctrl_unit_pipe dut0 (
      .Clock(Clock), .Reset_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
      .OP(op), .Funct3(f3), .F25(f25), .F30(f30), .IR21(ir21),
      .stall(stall), .flush(flush), .out_valid(ov0), .ALU_OP(aop0),
      .ALU_SRC(src0), .RegWrite(rw0), .MemToReg(m2r0), .MemWrite(mw0),
      .SB(sb0), .S_type(st0), .Beq(beq0), .Bne(bne0), .BLTU(bltu0),
      .JAL(jal0), .Jalr(jalr0), .CSRRSI(rsi0), .CSRRCI(rci0),
      .ecall(ec0), .uret(ur0), .illegal(ill0), .trap_busy(busy0)
   );

   ctrl_unit_pipe #(.ALUOP_W(5), .TRAP_CYCLES(3), .EN_CSR(0)) dut1 (
      .Clock(Clock), .Reset_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
      .OP(op), .Funct3(f3), .F25(f25), .F30(f30), .IR21(ir21),
      .stall(stall), .flush(flush), .out_valid(ov1), .ALU_OP(aop1),
      .ALU_SRC(src1), .RegWrite(rw1), .MemToReg(m2r1), .MemWrite(mw1),
      .SB(sb1), .S_type(st1), .Beq(beq1), .Bne(bne1), .BLTU(bltu1),
      .JAL(jal1), .Jalr(jalr1), .CSRRSI(rsi1), .CSRRCI(rci1),
      .ecall(ec1), .uret(ur1), .illegal(ill1), .trap_busy(busy1)
   );

   int unsigned vecs = 0;
   int unsigned errs = 0;

   // Reference model: per-instance issued bundle, valid flag and trap cycles left
   logic [19:0] m_bun[2];
   logic        m_val[2];
   int          m_trap[2];
   int          trapc[2]   = '{2, 3};
   int          alu_tab[8] = '{5, 0, 11, 12, 9, 2, 8, 7};
   logic [4:0]  ops[8]     = '{5'b01100, 5'b00100, 5'b00000, 5'b01000,
                               5'b11000, 5'b11011, 5'b11001, 5'b11100};

   // Bundle as {alu_op[3:0], src, rw, m2r, mw, sb, s_type, beq, bne, bltu, jal, jalr, rsi, rci, ecall, uret, illegal}
   function automatic logic [19:0] m_dec(input logic [4:0] o, input logic [2:0] f,
                                         input logic b25, input logic b30, input logic b21,
                                         input bit csr);
      int alu;
      bit src, rw, m2r, mw, sbb, st, beq, bne, bltu, jal, jalr, rsi, rci, ec, ur, ill;
      alu = 0; src = 0; rw = 0; m2r = 0; mw = 0; sbb = 0; st = 0; beq = 0; bne = 0;
      bltu = 0; jal = 0; jalr = 0; rsi = 0; rci = 0; ec = 0; ur = 0; ill = 0;
      if (o == 5'b01100) begin
         rw = 1; alu = alu_tab[f];
         if (b30 && f == 3'd0) alu = 6;
         if (b30 && f == 3'd5) alu = 1;
         ill = b25;
      end else if (o == 5'b00100) begin
         src = 1; rw = 1; alu = alu_tab[f];
         if (b30 && f == 3'd5) alu = 1;
      end else if (o == 5'b00000) begin
         src = 1; rw = 1; m2r = 1; alu = 5; ill = (f != 3'd2);
      end else if (o == 5'b01000) begin
         src = 1; mw = 1; st = 1; alu = 5; sbb = (f == 3'd0);
         ill = !(f == 3'd0 || f == 3'd2);
      end else if (o == 5'b11000) begin
         alu = 6; beq = (f == 3'd0); bne = (f == 3'd1); bltu = (f == 3'd6);
         ill = !(beq || bne || bltu);
      end else if (o == 5'b11011) begin
         jal = 1; rw = 1;
      end else if (o == 5'b11001) begin
         jalr = 1; src = 1; rw = 1; alu = 5;
      end else if (o == 5'b11100) begin
         if (f == 3'd0) begin ec = !b21; ur = b21; end
         else if (csr && f == 3'd6) begin rsi = 1; rw = 1; end
         else if (csr && f == 3'd7) begin rci = 1; rw = 1; end
         else ill = 1;
      end else begin
         ill = 1;
      end
      if (ill) return 20'h00001;
      return {4'(alu), src, rw, m2r, mw, sbb, st, beq, bne, bltu, jal, jalr, rsi, rci, ec, ur, 1'b0};
   endfunction

   function automatic bit m_ready(input int k);
      return !stall && (m_trap[k] == 0);
   endfunction

   // Advance one clock, stepping the model with the inputs seen at the edge
   task automatic tick();
      logic [19:0] d;
      bit acc;
      for (int k = 0; k < 2; k++) begin
         d   = m_dec(op, f3, f25, f30, ir21, k == 0);
         acc = in_valid && m_ready(k);
         if (!rst_n) begin
            m_val[k] = 1'b0; m_bun[k] = '0; m_trap[k] = 0;
         end else begin
            if (m_trap[k] > 0) m_trap[k]--;
            if (flush) begin
               m_val[k] = 1'b0; m_bun[k] = '0;
            end else if (stall) begin
            end else if (acc) begin
               m_val[k] = 1'b1; m_bun[k] = d;
            end else begin
               m_val[k] = 1'b0; m_bun[k] = '0;
            end
            if (acc && !flush && (d[2] || d[1])) m_trap[k] = trapc[k];
         end
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] o, input logic [2:0] f,
                        input logic b30, input logic b21);
      in_valid = v; op = o; f3 = f; f30 = b30; ir21 = b21; f25 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(1'b1, 5'b01100, 3'b000, 1'b0, 1'b0);
      tick();
      vecs++;
      if ({act0, act1, busy0, busy1} !== 46'd0) begin
         errs++; $display("FAIL reset_outputs: got %h %h busy %b%b, want all 0", act0, act1, busy0, busy1);
      end
      vecs++;
      if (rdy0 !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", rdy0); end
      rst_n = 1'b1;
      tick();
      vecs++;
      if ({ov0, aop0, rw0, src0} !== {1'b1, 4'd5, 1'b1, 1'b0}) begin
         errs++; $display("FAIL reset_release_add: got v=%b op=%0d rw=%b src=%b, want 1 5 1 0", ov0, aop0, rw0, src0);
      end
   endtask

   task automatic test_rtype_sub();
      drive(1'b1, 5'b01100, 3'b000, 1'b1, 1'b0);
      tick();
      vecs++;
      if ({ov0, aop0, rw0, src0} !== {1'b1, 4'd6, 1'b1, 1'b0}) begin
         errs++; $display("FAIL rtype_sub: got v=%b op=%0d rw=%b src=%b, want 1 6 1 0", ov0, aop0, rw0, src0);
      end
   endtask

   task automatic test_store();
      drive(1'b1, 5'b01000, 3'b000, 1'b0, 1'b0);
      tick();
      vecs++;
      if ({ov0, mw0, sb0, st0, src0, aop0, rw0} !== {5'b11111, 4'd5, 1'b0}) begin
         errs++; $display("FAIL store_byte: got v=%b mw=%b sb=%b st=%b src=%b op=%0d rw=%b, want 1 1 1 1 1 5 0",
                          ov0, mw0, sb0, st0, src0, aop0, rw0);
      end
      drive(1'b1, 5'b01000, 3'b011, 1'b0, 1'b0);
      tick();
      vecs++;
      if ({ov0, ill0, mw0, st0, src0} !== 5'b11000) begin
         errs++; $display("FAIL store_illegal: got v=%b ill=%b mw=%b st=%b src=%b, want 1 1 0 0 0", ov0, ill0, mw0, st0, src0);
      end
   endtask

   task automatic test_stall_flush();
      drive(1'b1, 5'b11000, 3'b001, 1'b0, 1'b0);
      tick();
      vecs++;
      if ({ov0, bne0, beq0, aop0} !== {3'b110, 4'd6}) begin
         errs++; $display("FAIL bne_issue: got v=%b bne=%b beq=%b op=%0d, want 1 1 0 6", ov0, bne0, beq0, aop0);
      end
      stall = 1'b1;
      drive(1'b1, 5'b01100, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         vecs++;
         if (rdy0 !== 1'b0) begin errs++; $display("FAIL stall_ready: got %b want 0", rdy0); end
         tick();
         vecs++;
         if ({ov0, bne0, rw0} !== 3'b110) begin
            errs++; $display("FAIL stall_hold: cycle %0d got v=%b bne=%b rw=%b, want 1 1 0", i, ov0, bne0, rw0);
         end
      end
      flush = 1'b1;
      tick();
      vecs++;
      if ({ov0, bne0, act0} !== 24'd0) begin
         errs++; $display("FAIL flush_over_stall: got v=%b bne=%b bundle=%h, want 0", ov0, bne0, act0);
      end
      flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      tick();
   endtask

   task automatic test_trap();
      drive(1'b1, 5'b11100, 3'b000, 1'b0, 1'b0);
      tick();
      vecs++;
      if ({ov0, ec0, ur0, busy0, rdy0} !== 5'b11010) begin
         errs++; $display("FAIL ecall_issue: got v=%b ec=%b ur=%b busy=%b rdy=%b, want 1 1 0 1 0", ov0, ec0, ur0, busy0, rdy0);
      end
      drive(1'b1, 5'b01100, 3'b000, 1'b0, 1'b0);
      tick();
      vecs++;
      if ({ov0, ec0, busy0, rdy0} !== 4'b0010) begin
         errs++; $display("FAIL trap_hold: got v=%b ec=%b busy=%b rdy=%b, want 0 0 1 0", ov0, ec0, busy0, rdy0);
      end
      tick();
      vecs++;
      if ({ov0, busy0, rdy0} !== 3'b001) begin
         errs++; $display("FAIL trap_exit: got v=%b busy=%b rdy=%b, want 0 0 1", ov0, busy0, rdy0);
      end
      tick();
      drive(1'b1, 5'b11100, 3'b000, 1'b0, 1'b1);
      tick();
      vecs++;
      if ({ov0, ur0, ec0, busy0, ur1} !== 5'b11011) begin
         errs++; $display("FAIL uret_issue: got v=%b ur=%b ec=%b busy=%b ur1=%b, want 1 1 0 1 1", ov0, ur0, ec0, busy0, ur1);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_reset_mid_trap();
      drive(1'b1, 5'b11100, 3'b000, 1'b0, 1'b0);
      tick();
      vecs++;
      if (busy0 !== 1'b1) begin errs++; $display("FAIL midtrap_enter: got busy=%b want 1", busy0); end
      in_valid = 1'b0; rst_n = 1'b0;
      tick();
      vecs++;
      if ({busy0, busy1, rdy0, rdy1} !== 4'b0011) begin
         errs++; $display("FAIL midtrap_reset: got busy=%b%b rdy=%b%b, want 00 11", busy0, busy1, rdy0, rdy1);
      end
      rst_n = 1'b1;
      drive(1'b1, 5'b11100, 3'b110, 1'b0, 1'b0);
      tick();
      vecs++;
      if ({ov1, ill1, rsi1, rw1, ov0, rsi0, rw0, ill0} !== 8'b1100_1110) begin
         errs++; $display("FAIL csr_enable: got n=%b%b%b%b e=%b%b%b%b, want 1100 1110",
                          ov1, ill1, rsi1, rw1, ov0, rsi0, rw0, ill0);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      int r;
      for (int n = 0; n < 400; n++) begin
         rst_n    = ($urandom_range(49) != 0);
         stall    = ($urandom_range(4) == 0);
         flush    = ($urandom_range(7) == 0);
         in_valid = ($urandom_range(3) != 0);
         r        = $urandom_range(9);
         op       = (r > 7) ? 5'($urandom) : ops[r];
         f3       = 3'($urandom);
         f25      = ($urandom_range(7) == 0);
         f30      = 1'($urandom);
         ir21     = 1'($urandom);
         #1;
         vecs++;
         if ({rdy0, rdy1} !== {m_ready(0), m_ready(1)}) begin
            errs++; $display("FAIL rand_ready: n=%0d got %b%b want %b%b", n, rdy0, rdy1, m_ready(0), m_ready(1));
         end
         tick();
         vecs++;
         if (act0 !== {1'b0, m_val[0], m_bun[0]}) begin
            errs++; $display("FAIL rand_bundle0: n=%0d got %h want %h", n, act0, {1'b0, m_val[0], m_bun[0]});
         end
         vecs++;
         if (act1 !== {1'b0, m_val[1], m_bun[1]}) begin
            errs++; $display("FAIL rand_bundle1: n=%0d got %h want %h", n, act1, {1'b0, m_val[1], m_bun[1]});
         end
         vecs++;
         if ({busy0, busy1} !== {m_trap[0] > 0, m_trap[1] > 0}) begin
            errs++; $display("FAIL rand_busy: n=%0d got %b%b want trap left %0d/%0d", n, busy0, busy1, m_trap[0], m_trap[1]);
         end
      end
   endtask

   initial begin
      m_val   = '{1'b0, 1'b0};
      m_bun   = '{20'd0, 20'd0};
      m_trap  = '{0, 0};
      rst_n   = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(1'b0, 5'b00000, 3'b000, 1'b0, 1'b0);
      test_reset();
      test_rtype_sub();
      test_store();
      test_stall_flush();
      test_trap();
      test_reset_mid_trap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
